booth_mul: RTL and testbench
============================

# booth_mul

Sequential radix-4 Booth multiplier: the parametrised successor of the team's shift-add `mul` core. It multiplies two N-bit operands, signed or unsigned per operation, and retires two multiplier bits per clock. It uses the same start/done handshake as `mul`, so it drops into existing datapaths and benches, and adds a `busy` flag and a signed mode.

## Interface
- `N`, default 8: operand width; must be even and ≥ 4. Elaboration fails otherwise.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `m` input, N bits: multiplicand; sampled only on the accepting edge.
- `r` input, N bits: multiplier; sampled only on the accepting edge.
- `sgn` input, 1 bit: 1 treats `m` and `r` as two's complement, 0 as unsigned; sampled on the accepting edge.
- `start` input, 1 bit: request; accepted on a rising edge when the block is idle.
- `prod` output, 2N bits: product; valid from `done` until the next accepting edge.
- `done` output, 1 bit: one-cycle pulse marking `prod` valid.
- `busy` output, 1 bit: high while an operation is in progress.

## Operation
- Internal width W = N+2, iteration count K = W/2.
- Operands are extended to W bits: sign-extended when `sgn`=1, zero-extended when `sgn`=0. This makes unsigned full-range operands exact.
- FSM has two states:
  - IDLE -> RUN on an edge with `start`=1. Operands and `sgn` are latched, the accumulator is cleared, the iteration counter is set to K, and `busy` is set.
  - RUN lasts K edges. Each edge:
    - Recode the multiplier triplet {r[2i+1], r[2i], r[2i-1]} (r[-1]=0) into a digit in {0, ±M, ±2M}.
    - Add the digit to the upper accumulator.
    - Arithmetic-shift the accumulator right by 2.
    - Decrement the counter.
  - RUN -> IDLE on the edge where the counter reaches its last iteration. On that edge: `prod` <= low 2N bits of the final accumulator, `done` <= 1, `busy` <= 0.
- Accumulator width is 2W+1 bits; the adder is W+2 bits wide so ±2M never overflows.
- Truncation to 2N bits is exact in both modes.
- `done` is cleared on the next edge. `prod` holds its value until the next accepting edge, where it is not cleared; it is simply overwritten at the next completion.
- `start` is ignored while `busy`=1. It is not queued.
- `start`=1 while `done`=1 is accepted, since the FSM is already IDLE. This gives back-to-back operation.
- Holding `start` high continuously restarts an operation each time the block returns to IDLE.
- Changes on `m`, `r` or `sgn` during RUN have no effect.

## Timing
- Reset values: `prod`=0, `done`=0, `busy`=0, FSM=IDLE, counter=0.
- Reset mid-operation aborts immediately, leaving outputs at their reset values. No `done` is produced for the aborted operation.
- Latency: if `start` is accepted at edge t, then `busy`=1 after t, and `done`=1 with `prod` valid after edge t+K.
- For N=4, K=3. For N=8, K=5.
- Throughput: one result every K cycles with back-to-back `start`.
- `done` and `busy` are never high together. `busy` is high for exactly K cycles per operation.

## Structure
- Shared package `mul_pkg`:
  - FSM state enum (IDLE, RUN).
  - Booth digit encoding constants (ZERO, PM1, PM2, sign bit).
  - The W = N+2 and K = W/2 derivation as localparam helpers.
- Sub-module `booth_enc`:
  - Combinational radix-4 recoder.
  - Input: 3-bit triplet. Outputs: `neg`, `one`, `two`.
  - The core instantiates it once and forms the ±M/±2M addend.

## Test plan
- N=4, `sgn`=0, m=5, r=6, `start` pulsed 2 cycles from reset release -> `done` after 3 edges, `prod`=8'd30. The pulse must not trigger a second run while `busy`.
- N=4, `sgn`=0, m=15, r=15 -> `prod`=8'hE1 (225). `sgn`=1 with the same bits (-1 × -1) -> `prod`=8'h01.
- N=4, `sgn`=1, m=-8 (4'h8), r=7 -> `prod`=8'hC8 (-56). m=-8, r=-8 -> `prod`=8'h40.
- N=4, `start` reasserted at the `done` cycle with m=3, r=3 -> second `done` 3 edges later with `prod`=8'd9. The first `prod` stays held through the second run.
- N=4, assert `rst` one edge after acceptance -> `busy`=`done`=0 and `prod`=0 immediately. No `done` appears afterwards.
- N=8, 2000 random operands in both modes, including 0, -128, 127 and 255 -> `prod` matches a behavioural reference model and `done` arrives exactly 5 edges after acceptance.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier cores: FSM states, Booth digit
// encoding and the operand-width derivations.
package mul_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Booth digit: magnitude code in bits [1:0], sign in bit DIG_SIGN_BIT
    localparam logic [1:0]  DIG_ZERO     = 2'b00;
    localparam logic [1:0]  DIG_PM1      = 2'b01;
    localparam logic [1:0]  DIG_PM2      = 2'b10;
    localparam int unsigned DIG_SIGN_BIT = 2;

    // Internal width: two guard bits make full-range unsigned operands exact
    function automatic int calc_w(input int n);
        return n + 2;
    endfunction

    // Iteration count: two multiplier bits retired per cycle
    function automatic int calc_k(input int n);
        return (n + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_enc.sv
// Combinational radix-4 Booth recoder: triplet {r[2i+1], r[2i], r[2i-1]}
// to a digit in {0, +-1, +-2}.
module booth_enc
    import mul_pkg::*;
(
    input  logic [2:0] trip,
    output logic       neg,
    output logic       one,
    output logic       two
);

    logic [2:0] dig;

    // Recode triplet into sign/magnitude digit
    always_comb begin
        dig = {1'b0, DIG_ZERO};
        case (trip)
            3'b001, 3'b010: dig = {1'b0, DIG_PM1};
            3'b011:         dig = {1'b0, DIG_PM2};
            3'b100:         dig = {1'b1, DIG_PM2};
            3'b101, 3'b110: dig = {1'b1, DIG_PM1};
            default:        dig = {1'b0, DIG_ZERO};
        endcase
        neg = dig[DIG_SIGN_BIT];
        one = (dig[1:0] == DIG_PM1);
        two = (dig[1:0] == DIG_PM2);
    end

endmodule

// File: rtl/booth_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation,
// start/done handshake with busy flag.
module booth_mul
    import mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   r,
    input  logic           sgn,
    input  logic           start,
    output logic [2*N-1:0] prod,
    output logic           done,
    output logic           busy
);

    localparam int W  = calc_w(N);
    localparam int K  = calc_k(N);
    localparam int CW = $clog2(K + 1);
    localparam int AW = 2 * W + 1;
    localparam int SW = W + 2;

    generate
        if (N < 4 || (N % 2) != 0) begin : g_bad_n
            $error("booth_mul: N must be even and >= 4");
        end
    endgenerate

    state_t        state, state_nx;
    logic [W-1:0]  mreg;
    // acc = {upper accumulator A (W bits), multiplier Q (W bits), r[-1]}
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nx;
    logic [CW-1:0] cnt;
    logic          neg, one, two;
    logic [SW-1:0] mag, addend, sum;
    logic          accept, last;

    booth_enc u_enc (
        .trip (acc[2:0]),
        .neg  (neg),
        .one  (one),
        .two  (two)
    );

    // Form the +-M/+-2M addend and the next shifted accumulator
    always_comb begin
        mag = '0;
        if (one) begin
            mag = {{2{mreg[W-1]}}, mreg};
        end else if (two) begin
            mag = {mreg[W-1], mreg, 1'b0};
        end
        addend = neg ? (~mag + SW'(1)) : mag;
        sum    = {{2{acc[AW-1]}}, acc[AW-1:W+1]} + addend;
        // arithmetic shift by 2: new A is sum/4, sum[1:0] enter the top of Q
        acc_nx = {sum, acc[W:2]};
    end

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == CW'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and busy flag
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mreg <= '0;
            acc  <= '0;
            cnt  <= '0;
            prod <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mreg <= {{2{sgn & m[N-1]}}, m};
                acc  <= {{W{1'b0}}, {2{sgn & r[N-1]}}, r, 1'b0};
                cnt  <= CW'(K);
            end else if (state == RUN) begin
                acc <= acc_nx;
                cnt <= cnt - CW'(1);
                if (last) begin
                    prod <= acc_nx[2*N:1];
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul at N=4 (directed) and N=8 (random).
module tb_booth_mul;

    localparam int K4 = 3;
    localparam int K8 = 5;

    logic       clk = 1'b0;
    logic       rst4, rst8;
    logic [3:0] m4, r4;
    logic [7:0] m8, r8;
    logic       sgn4, sgn8, start4, start8;
    logic [7:0]  prod4;
    logic [15:0] prod8;
    logic       done4, busy4, done8, busy8;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    booth_mul #(.N(4)) dut4 (
        .clk(clk), .rst(rst4), .m(m4), .r(r4), .sgn(sgn4), .start(start4),
        .prod(prod4), .done(done4), .busy(busy4)
    );

    booth_mul #(.N(8)) dut8 (
        .clk(clk), .rst(rst8), .m(m8), .r(r8), .sgn(sgn8), .start(start8),
        .prod(prod8), .done(done8), .busy(busy8)
    );

    typedef struct {
        logic       s;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            if (mismatched <= 30)
                $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: integer product of the interpreted operands, truncated
    function automatic logic [15:0] ref_mul(input int n, input logic s,
                                            input logic [7:0] a, input logic [7:0] b);
        longint x, y, p;
        x = longint'(a);
        y = longint'(b);
        if (s && a[n-1]) x = x - (longint'(1) << n);
        if (s && b[n-1]) y = y - (longint'(1) << n);
        p = x * y;
        return 16'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    // One N=4 operation; start held for 'hold' edges; inputs scrambled after acceptance
    task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b, input int hold,
                       output logic [7:0] p, output int lat, output int bcnt, output int both);
        @(negedge clk);
        sgn4 = s; m4 = a; r4 = b; start4 = 1'b1;
        lat = -1; bcnt = 0; both = 0;
        for (int e = 1; e <= K4 + 4; e++) begin
            @(posedge clk); #1;
            if (e >= hold) start4 = 1'b0;
            m4 = 4'($urandom); r4 = 4'($urandom); sgn4 = 1'($urandom);
            if (busy4) bcnt++;
            if (busy4 && done4) both++;
            if (done4) begin
                lat = e - 1;
                break;
            end
        end
        p = prod4;
    endtask

    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat);
        @(negedge clk);
        sgn8 = s; m8 = a; r8 = b; start8 = 1'b1;
        lat = -1;
        for (int e = 1; e <= K8 + 4; e++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            m8 = 8'($urandom); r8 = 8'($urandom); sgn8 = 1'($urandom);
            if (done8) begin
                lat = e - 1;
                break;
            end
        end
        p = prod8;
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'h7F;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [7:0]  p4, first;
        logic [15:0] p8;
        int lat, bcnt, both, extra;

        vt[0] = '{1'b0, 4'd5,  4'd6,  8'd30};
        vt[1] = '{1'b0, 4'hF,  4'hF,  8'hE1};
        vt[2] = '{1'b1, 4'hF,  4'hF,  8'h01};
        vt[3] = '{1'b1, 4'h8,  4'd7,  8'hC8};
        vt[4] = '{1'b1, 4'h8,  4'h8,  8'h40};
        vt[5] = '{1'b0, 4'd0,  4'd9,  8'h00};
        vt[6] = '{1'b1, 4'd7,  4'd7,  8'h31};
        vt[7] = '{1'b1, 4'h8,  4'd1,  8'hF8};

        rst4 = 1'b1; rst8 = 1'b1;
        m4 = '0; r4 = '0; sgn4 = 1'b0; start4 = 1'b0;
        m8 = '0; r8 = '0; sgn8 = 1'b0; start8 = 1'b0;
        #1;
        chk("reset_prod4", 64'(prod4), 64'h0);
        chk("reset_done4", 64'(done4), 64'h0);
        chk("reset_busy4", 64'(busy4), 64'h0);
        chk("reset_prod8", 64'(prod8), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;

        // 2-cycle start pulse must give a single run
        op4(1'b0, 4'd5, 4'd6, 2, p4, lat, bcnt, both);
        chk("pulse_prod", 64'(p4), 64'd30);
        chk("pulse_lat", 64'(lat), 64'(K4));
        extra = 0;
        for (int e = 0; e < K4 + 2; e++) begin
            @(posedge clk); #1;
            if (done4 || busy4) extra++;
        end
        chk("pulse_no_rerun", 64'(extra), 64'h0);

        for (int i = 0; i < 8; i++) begin
            op4(vt[i].s, vt[i].a, vt[i].b, 1, p4, lat, bcnt, both);
            chk($sformatf("vec%0d_prod", i), 64'(p4), 64'(vt[i].p));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(K4));
            chk($sformatf("vec%0d_busy", i), 64'(bcnt), 64'(K4));
            chk($sformatf("vec%0d_overlap", i), 64'(both), 64'h0);
        end

        // Back-to-back: start raised during the done cycle
        op4(1'b0, 4'd2, 4'd7, 1, first, lat, bcnt, both);
        chk("b2b_first", 64'(first), 64'd14);
        chk("b2b_done_seen", 64'(done4), 64'h1);
        m4 = 4'd3; r4 = 4'd3; sgn4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("b2b_busy", 64'(busy4), 64'h1);
        chk("b2b_done_clr", 64'(done4), 64'h0);
        lat = -1; extra = 0;
        for (int e = 1; e <= K4 + 3; e++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = e;
                break;
            end
            if (prod4 !== first) extra++;
        end
        chk("b2b_hold", 64'(extra), 64'h0);
        chk("b2b_lat", 64'(lat), 64'(K4));
        chk("b2b_prod", 64'(prod4), 64'd9);

        // Reset one edge after acceptance aborts the operation
        @(negedge clk);
        m4 = 4'd7; r4 = 4'd5; sgn4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst4 = 1'b1;
        #1;
        chk("abort_busy", 64'(busy4), 64'h0);
        chk("abort_done", 64'(done4), 64'h0);
        chk("abort_prod", 64'(prod4), 64'h0);
        @(negedge clk);
        rst4 = 1'b0;
        extra = 0;
        for (int e = 0; e < K4 + 3; e++) begin
            @(posedge clk); #1;
            if (done4 || busy4) extra++;
        end
        chk("abort_no_done", 64'(extra), 64'h0);

        // Random N=8 operations in both modes
        for (int i = 0; i < 2000; i++) begin
            logic       s;
            logic [7:0] a, b;
            s = 1'(i % 2);
            a = pick8();
            b = pick8();
            op8(s, a, b, p8, lat);
            chk($sformatf("rnd%0d_prod s=%0d m=%0h r=%0h", i, s, a, b), 64'(p8), 64'(ref_mul(8, s, a, b)));
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(K8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
